// File: rtl/tx_timer_ctrl.sv
// Transmit timer sequencer: walks a packet through LATCH, SYNC, DATA and EOP
// using rising edges of the timer rollover flags, and strobes byte fetches.
module tx_timer_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int EOP_BITS  = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       start,
  input  logic [6:0] tx_packet_size,
  input  logic       abort,
  input  logic       rollover_flag8,
  input  logic       rollover_flag64,
  input  logic       rollover_flag512,
  output logic       count_enable,
  output logic       latch_packet_size,
  output logic       clear,
  output logic [6:0] timer_size,
  output logic       byte_pop,
  output logic       tx_active,
  output logic       eop_drive,
  output logic       done,
  output logic       aborted,
  output logic       size_err
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_SYNC  = 3'd2,
    S_DATA  = 3'd3,
    S_EOP   = 3'd4
  } state_t;

  localparam logic [6:0] MAX_SIZE = 7'(MAX_BYTES);
  localparam logic [1:0] EOP_LAST = 2'(EOP_BITS - 1);

  state_t     state_q, state_d;
  logic [6:0] size_q, size_d;
  logic [1:0] eop_cnt_q, eop_cnt_d;
  logic       size_err_q, size_err_d;
  logic       flag8_q, flag64_q, flag512_q;
  logic       rise8, rise64, rise512;
  logic       size_ok;

  // Flags are levels from the timer; only their rising edges step the sequence.
  assign rise8   = rollover_flag8   & ~flag8_q;
  assign rise64  = rollover_flag64  & ~flag64_q;
  assign rise512 = rollover_flag512 & ~flag512_q;
  assign size_ok = (tx_packet_size != 7'd0) && (tx_packet_size <= MAX_SIZE);

  assign tx_active  = (state_q != S_IDLE);
  assign eop_drive  = (state_q == S_EOP);
  assign timer_size = size_q;
  assign size_err   = size_err_q;

  always_comb begin
    state_d           = state_q;
    size_d            = size_q;
    eop_cnt_d         = eop_cnt_q;
    size_err_d        = 1'b0;
    count_enable      = 1'b0;
    latch_packet_size = 1'b0;
    clear             = 1'b0;
    byte_pop          = 1'b0;
    done              = 1'b0;
    aborted           = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (size_ok) begin
            size_d  = tx_packet_size;
            state_d = S_LATCH;
          end else begin
            size_err_d = 1'b1;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LATCH: begin
        latch_packet_size = 1'b1;
        clear             = 1'b1;
        state_d           = S_SYNC;
      end
      S_SYNC: begin
        // The SYNC-to-DATA transition fetches byte 0 so it is ready at DATA entry.
        if (rise64) begin
          clear    = 1'b1;
          byte_pop = 1'b1;
          state_d  = S_DATA;
        end else begin
          count_enable = 1'b1;
        end
      end
      S_DATA: begin
        // Packet-complete wins over the coincident byte flag: the last byte is already out.
        if (rise512) begin
          clear     = 1'b1;
          eop_cnt_d = 2'd0;
          state_d   = S_EOP;
        end else begin
          count_enable = 1'b1;
          byte_pop     = rise64;
        end
      end
      S_EOP: begin
        count_enable = 1'b1;
        if (rise8) begin
          if (eop_cnt_q == EOP_LAST) begin
            clear     = 1'b1;
            done      = 1'b1;
            eop_cnt_d = 2'd0;
            state_d   = S_IDLE;
          end else begin
            eop_cnt_d = eop_cnt_q + 2'd1;
          end
        end else begin
          eop_cnt_d = eop_cnt_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort is checked last so it overrides any flag edge seen in the same cycle.
    if (abort && (state_q != S_IDLE)) begin
      state_d      = S_IDLE;
      eop_cnt_d    = 2'd0;
      clear        = 1'b1;
      aborted      = 1'b1;
      count_enable = 1'b0;
      byte_pop     = 1'b0;
      done         = 1'b0;
    end else begin
      aborted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q    <= S_IDLE;
      size_q     <= 7'd0;
      eop_cnt_q  <= 2'd0;
      size_err_q <= 1'b0;
      flag8_q    <= 1'b0;
      flag64_q   <= 1'b0;
      flag512_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      size_q     <= size_d;
      eop_cnt_q  <= eop_cnt_d;
      size_err_q <= size_err_d;
      flag8_q    <= rollover_flag8;
      flag64_q   <= rollover_flag64;
      flag512_q  <= rollover_flag512;
    end
  end

endmodule

// File: tb/tb_tx_timer_ctrl.sv
// Scoreboard bench for tx_timer_ctrl: a simple timer model closes the loop and
// expected events are computed from packet size / abort point arithmetic.
module tb_tx_timer_ctrl;

  localparam int EB   = 2;
  localparam int MAXB = 64;
  localparam int K_LATCH = 0, K_POP = 1, K_DONE = 2, K_ABORT = 3, K_SERR = 4;

  typedef struct {
    int kind;
    int cyc;
    int v0;
    int v1;
  } ev_t;

  logic       clk = 1'b0;
  logic       n_rst, start, abort;
  logic [6:0] tx_packet_size;
  logic       rollover_flag8, rollover_flag64, rollover_flag512;
  logic       count_enable, latch_packet_size, clear, byte_pop;
  logic       tx_active, eop_drive, done, aborted, size_err;
  logic [6:0] timer_size;

  int   cyc = 0;
  int   tcnt = 0;
  int   tsize = 0;
  logic force64 = 1'b0;
  logic s_ce = 1'b0, s_clr = 1'b0, s_lat = 1'b0;
  int   s_tsz = 0;
  int   act_cnt = 0, eop_cnt = 0;
  int   errors = 0, checks = 0;
  int   carry_ab = 0;
  ev_t  exp_q[$];

  tx_timer_ctrl #(.MAX_BYTES(MAXB), .EOP_BITS(EB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .tx_packet_size(tx_packet_size),
    .abort(abort), .rollover_flag8(rollover_flag8), .rollover_flag64(rollover_flag64),
    .rollover_flag512(rollover_flag512), .count_enable(count_enable),
    .latch_packet_size(latch_packet_size), .clear(clear), .timer_size(timer_size),
    .byte_pop(byte_pop), .tx_active(tx_active), .eop_drive(eop_drive), .done(done),
    .aborted(aborted), .size_err(size_err)
  );

  always #5 clk = ~clk;

  // Timer model: counts enabled cycles since the last clear.
  assign rollover_flag8   = (tcnt != 0) && (tcnt % 8 == 0);
  assign rollover_flag64  = ((tcnt != 0) && (tcnt % 64 == 0)) || force64;
  assign rollover_flag512 = (tsize != 0) && (tcnt == 64 * tsize);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (n_rst) begin
      tcnt  <= 0;
      tsize <= 0;
    end else begin
      if (s_lat) tsize <= s_tsz;
      if (s_clr) tcnt <= 0;
      else if (s_ce) tcnt <= tcnt + 1;
    end
  end

  always @(negedge clk) begin
    s_ce  <= count_enable;
    s_clr <= clear;
    s_lat <= latch_packet_size;
    s_tsz <= int'(timer_size);
  end

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, expv);
    end
  endtask

  task automatic push(input int kind, input int c, input int v0, input int v1);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.v0   = v0;
    e.v1   = v1;
    exp_q.push_back(e);
  endtask

  task automatic got(input int kind, input int v0, input int v1);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      chk("event_v0", v0, e.v0);
      chk("event_v1", v1, e.v1);
    end
  endtask

  // Monitor: every strobe is matched against the head of the expected queue.
  always @(negedge clk) begin
    if (latch_packet_size) got(K_LATCH, int'(timer_size), int'({clear, count_enable}));
    if (byte_pop)          got(K_POP, 0, int'({clear, count_enable}));
    if (done)              got(K_DONE, act_cnt + int'(tx_active),
                               (eop_cnt + int'(eop_drive)) * 4 + int'({clear, count_enable}));
    if (aborted)           got(K_ABORT, act_cnt + int'(tx_active), int'({clear, count_enable}));
    if (size_err)          got(K_SERR, int'(tx_active), int'({latch_packet_size, count_enable}));
    if (n_rst || done || aborted || !tx_active) act_cnt <= 0;
    else act_cnt <= act_cnt + 1;
    if (n_rst || done || aborted || !eop_drive) eop_cnt <= 0;
    else eop_cnt <= eop_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input int exp_size);
    chk("idle_outputs", int'({count_enable, latch_packet_size, clear, byte_pop, tx_active,
                              eop_drive, done, aborted, size_err}), 0);
    chk("idle_timer_size", int'(timer_size), exp_size);
  endtask

  // One request: n = size, ab = abort offset (0 none), hold_i = pop index after
  // which flag64 is held high 8 cycles (-1 none), mid = offset of an ignored start.
  task automatic run_pkt(input int n, input int ab, input int hold_i, input int mid);
    int c0, dn, last, t, hold_t;
    bit legal;
    c0     = cyc;
    dn     = 68 + 8 * EB + 64 * n;
    legal  = (n >= 1) && (n <= MAXB);
    hold_t = 87 + 64 * hold_i;
    if (!legal) begin
      push(K_SERR, c0 + 1, 0, 0);
      last = 1;
    end else begin
      last = (ab != 0) ? ab : dn;
      push(K_LATCH, c0 + 1, n, 2);
      for (int i = 0; i < n; i++) begin
        t = (i == 0) ? 66 : 67 + 64 * i;
        if (t < last) push(K_POP, c0 + t, 0, (i == 0) ? 2 : 1);
        if (hold_i == i && hold_t < last) push(K_POP, c0 + hold_t, 0, 1);
      end
      if (ab != 0) push(K_ABORT, c0 + ab, ab, 2);
      else push(K_DONE, c0 + dn, dn, (8 * EB + 1) * 4 + 3);
    end
    for (int k = 0; k <= last; k++) begin
      start          = (k == 0) || (mid > 0 && k == mid);
      tx_packet_size = (k == 0) ? 7'(n) : 7'($urandom_range(0, 127));
      abort          = (k == 0) ? (carry_ab != 0) : (ab != 0 && k == ab);
      force64        = (hold_i >= 0) && (k >= hold_t) && (k < hold_t + 8);
      step();
    end
    start    = 1'b0;
    force64  = 1'b0;
    abort    = (legal && ab != 0);
    carry_ab = (legal && ab != 0) ? 1 : 0;
  endtask

  // Request of size n, then synchronous reset a few cycles into EOP.
  task automatic run_rst(input int n);
    int c0, r;
    c0 = cyc;
    r  = 71 + 64 * n;
    push(K_LATCH, c0 + 1, n, 2);
    for (int i = 0; i < n; i++) push(K_POP, c0 + ((i == 0) ? 66 : 67 + 64 * i), 0, (i == 0) ? 2 : 1);
    for (int k = 0; k < r; k++) begin
      start          = (k == 0);
      tx_packet_size = 7'(n);
      abort          = (k == 0) ? (carry_ab != 0) : 1'b0;
      step();
    end
    n_rst = 1'b1;
    step();
    n_rst    = 1'b0;
    abort    = 1'b0;
    carry_ab = 0;
    chk_idle(0);
  endtask

  initial begin
    int n, ab, hi, md, dn, last;
    n_rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    tx_packet_size = 7'd0;
    step();
    step();
    chk_idle(0);
    n_rst = 1'b0;
    repeat (100) step();
    chk_idle(0);

    run_pkt(1, 0, -1, 0);
    run_pkt(4, 0, -1, 0);
    run_pkt(0, 0, -1, 0);
    run_pkt(65, 0, -1, 0);
    chk_idle(4);
    run_pkt(4, 195, -1, 0);     // abort on the cycle of the third pop
    run_pkt(2, 0, -1, 0);       // accepted with abort still high in IDLE
    run_pkt(3, 66, -1, 0);      // abort on the SYNC exit edge
    run_pkt(1, 148, -1, 0);     // abort on the final EOP edge
    run_pkt(3, 0, 1, 150);      // held flag64 plus a start during DATA
    run_rst(2);

    for (int it = 0; it < 14; it++) begin
      if ($urandom_range(0, 7) == 0) n = ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(65, 127));
      else n = int'($urandom_range(1, 6));
      ab = 0;
      hi = -1;
      md = 0;
      if (n >= 1 && n <= MAXB) begin
        dn = 68 + 8 * EB + 64 * n;
        if ($urandom_range(0, 3) == 0) ab = int'($urandom_range(1, dn));
        last = (ab != 0) ? ab : dn;
        if (ab == 0 && $urandom_range(0, 1) == 1) hi = int'($urandom_range(0, n - 1));
        if (last > 3 && $urandom_range(0, 1) == 1) md = int'($urandom_range(2, last - 1));
      end
      run_pkt(n, ab, hi, md);
    end

    abort = 1'b0;
    repeat (5) step();
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_timer_ctrl.md
# tx_timer_ctrl

Sequencer for the bit/byte/packet timer in the USB transmit path. Accepts a transmit request with a byte count and drives the timer's `count_enable`, `latch_packet_size` and `clear` inputs. It then steps through the SYNC, DATA and EOP phases using the timer's rollover flags, and tells the transmit datapath when to fetch each byte and when to drive EOP. It sits between the AHB-side transmit request logic and the timer/encoder pair.

## Interface
Parameters:
- MAX_BYTES, 64: largest legal packet size in bytes (1..127).
- EOP_BITS, 2: EOP length in bit times.

Ports:
- clk  in  1  system clock
- n_rst  in  1  reset; synchronous, active-high (1 = reset), sampled on rising clk
- start  in  1  one-cycle request to send a packet; honoured only in IDLE
- tx_packet_size  in  7  byte count for the request, sampled with start
- abort  in  1  level; terminates any active transfer
- rollover_flag8  in  1  timer bit-time flag
- rollover_flag64  in  1  timer byte-time flag
- rollover_flag512  in  1  timer packet-complete flag
- count_enable  out  1  timer count enable
- latch_packet_size  out  1  timer size latch strobe
- clear  out  1  timer clear strobe
- timer_size  out  7  size presented to timer tx_packet_size, registered copy of accepted size
- byte_pop  out  1  one-cycle fetch of next data byte
- tx_active  out  1  high from LATCH through EOP
- eop_drive  out  1  high during EOP
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort
- size_err  out  1  one-cycle pulse when start carries an illegal size

## Operation
- States: IDLE, LATCH, SYNC, DATA, EOP.
- Rollover flags are level signals that can stay high for several cycles. Each is edge-detected internally: `rise_x = flag_x & ~flag_x_q`, where `flag_x_q` is registered and reset to 0. Only rising edges advance the FSM.
- IDLE, start=1, size in 1..MAX_BYTES:
  - capture size into `timer_size`;
  - go to LATCH.
- IDLE, start=1, size 0 or >MAX_BYTES:
  - `size_err`=1 next cycle;
  - stay IDLE; `timer_size` unchanged.
- LATCH, one cycle: `latch_packet_size`=1, `clear`=1, `count_enable`=0. Then go to SYNC.
- SYNC: `count_enable`=1.
  - On rise_64: that cycle `count_enable`=0 and `clear`=1, then go to DATA.
  - `byte_pop`=1 in the same cycle, fetching byte 0.
- DATA: `count_enable`=1.
  - rise_64 without rise_512: `byte_pop`=1 for that cycle.
  - rise_512: `clear`=1, `count_enable`=0, `byte_pop`=0, then go to EOP.
- EOP: `count_enable`=1, `eop_drive`=1.
  - Count rise_8 events in a 2-bit counter.
  - On the EOP_BITS-th rise_8: `clear`=1, `done`=1, then go to IDLE.
- abort in any non-IDLE state:
  - next state IDLE;
  - `clear`=1 and `aborted`=1 for one cycle, `count_enable`=0;
  - abort overrides every simultaneous flag edge.
- abort in IDLE: ignored.
- start outside IDLE: ignored. No queuing.
- start and abort together in IDLE: start is honoured.
- `byte_pop` count per packet equals the accepted size exactly. SYNC carries no pop.

## Timing
- Reset values:
  - FSM in IDLE;
  - all strobes 0, `count_enable`=0, `tx_active`=0, `eop_drive`=0;
  - `timer_size`=0, edge registers 0, EOP counter 0.
- Reset mid-transfer: the next cycle is IDLE with all outputs at reset values. No `aborted` or `done` pulse. The timer is not cleared by this block; it shares the reset.
- All outputs are Moore/registered-state decodes. The edge-qualified strobes (`byte_pop`, `clear`, `done`, `aborted`) are combinational on the rise_x terms in the listed states and last exactly one cycle.
- start → `latch_packet_size`: 1 cycle. The timer sees the new size on the same cycle it is latched.
- SYNC duration: 64 enabled cycles plus 1 transition cycle.
- DATA duration: 64·N enabled cycles. N=1 gives a single pop at DATA entry, then rise_512 after 64 enables.
- EOP duration: 8·EOP_BITS enabled cycles.
- `tx_active` = (state ≠ IDLE). `done` is asserted on the last `tx_active` cycle.
- Flags arriving in IDLE or LATCH are ignored. Their edge registers still update.

## Test plan
- Reset with n_rst=1 for 2 cycles:
  - all outputs 0, state IDLE;
  - release, then no activity for 100 cycles with start=0.
- start, size=1:
  - `latch_packet_size` pulse with `timer_size`=1;
  - exactly 1 `byte_pop`, on the SYNC→DATA cycle;
  - `eop_drive` high for 16 enabled cycles, then `done`;
  - `tx_active` high for 2+64+64+16 cycles plus transition cycles.
- start, size=4: exactly 4 `byte_pop` pulses spaced 64 cycles apart, one `done`, no `aborted`.
- start with size=0, then size=65:
  - `size_err` pulses each time;
  - `latch_packet_size`, `count_enable` and `tx_active` never assert.
- abort asserted mid-DATA on the cycle of a rise_64:
  - no `byte_pop`;
  - `clear`=1 and `aborted`=1 for 1 cycle;
  - IDLE next cycle; a new start is accepted immediately.
- start while in DATA is ignored. Held-high `rollover_flag64` (8 cycles) produces one `byte_pop`. n_rst asserted in EOP gives IDLE next cycle with no `done`.
